// File: rtl/adc_sample_buffer_pkg.sv
// Shared constants and types for the codec-to-notch sample buffer.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package adc_sample_buffer_pkg;

    // Codec sample width; notch_top uses the same width.
    localparam int K = 24;

    // Stereo-to-mono mixing modes.
    localparam int MIX_LEFT  = 0;
    localparam int MIX_RIGHT = 1;
    localparam int MIX_AVG   = 2;

    // Default number of cycles allowed for notch_top to finish one sample.
    localparam int DEF_TIMEOUT = 4096;

    // Handshake FSM towards notch_top.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/adc_sample_buffer_sync_fifo.sv
// Synchronous FIFO with a separate occupancy counter and a drop flag for refused pushes.
// Latency: write visible at the head one cycle after push; head is readable combinationally.
// Backpressure: a push while full is dropped unless a pop in the same cycle frees the slot.
module sync_fifo #(
    parameter int W     = 24,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [W-1:0]  wr_dat,
    input  logic          pop,
    output logic [W-1:0]  rd_dat,
    output logic [AW:0]   count,
    output logic          empty,
    output logic          drop
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop & ~empty;
    // A pop in the same cycle frees the slot, so the push still fits.
    assign push_ok = push & (~full | pop_ok);
    assign drop    = push & full & ~pop_ok;
    assign rd_dat  = mem[rd_ptr];

    // Storage array; no reset needed since count gates every read.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/adc_sample_buffer.sv
// Captures codec stereo frames on ready rises, mixes to mono, queues them and feeds notch_top.
// Latency: strobe 2 edges after the capture edge when idle and empty.
// Backpressure: one sample in flight until filter_done rises or the timeout expires; full FIFO drops frames.
module adc_sample_buffer
    import adc_sample_buffer_pkg::*;
#(
    parameter int k       = K,
    parameter int DEPTH   = 8,
    parameter int AW      = 3,
    parameter int MIX     = MIX_AVG,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ready,
    input  logic [23:0]   L_bus_out,
    input  logic [23:0]   R_bus_out,
    input  logic          filter_done,
    output logic [k-1:0]  data_out,
    output logic          sample,
    output logic          busy,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic          timeout_err
);

    localparam int KW = k + 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t          state;
    logic            ready_d;
    logic            done_d;
    logic            ready_rise;
    logic            done_rise;
    logic [TW-1:0]   tcnt;
    logic            timeout_hit;
    logic signed [k:0] mix_sum;
    logic [k-1:0]    mix_dat;
    logic [k-1:0]    fifo_dat;
    logic            fifo_empty;
    logic            fifo_drop;
    logic            pop;

    assign ready_rise  = ready & ~ready_d;
    assign done_rise   = filter_done & ~done_d;
    assign timeout_hit = (TIMEOUT != 0) && (tcnt == TW'(TIMEOUT - 1));
    assign pop         = (state == ST_IDLE) & ~fifo_empty;

    // Delayed copies of ready and filter_done for rising-edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_d <= 1'b0;
            done_d  <= 1'b0;
        end else begin
            ready_d <= ready;
            done_d  <= filter_done;
        end
    end

    // Stereo-to-mono mix; the average is taken one bit wider so it cannot wrap.
    always_comb begin
        mix_sum = KW'($signed(L_bus_out)) + KW'($signed(R_bus_out));
        if (MIX == MIX_LEFT)       mix_dat = k'($signed(L_bus_out));
        else if (MIX == MIX_RIGHT) mix_dat = k'($signed(R_bus_out));
        else                       mix_dat = k'(mix_sum >>> 1);
    end

    sync_fifo #(
        .W     (k),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .push   (ready_rise),
        .wr_dat (mix_dat),
        .pop    (pop),
        .rd_dat (fifo_dat),
        .count  (count),
        .empty  (fifo_empty),
        .drop   (fifo_drop)
    );

    // Sticky record of frames lost to a full FIFO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) overflow <= 1'b0;
        else       overflow <= overflow | fifo_drop;
    end

    // Handshake FSM: issue one sample, then hold it until done rises or the wait times out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            data_out    <= '0;
            sample      <= 1'b0;
            busy        <= 1'b0;
            tcnt        <= '0;
            timeout_err <= 1'b0;
        end else begin
            sample <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        data_out <= fifo_dat;
                        sample   <= 1'b1;
                        busy     <= 1'b1;
                        tcnt     <= '0;
                        state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // A done edge wins over a coincident timeout.
                    if (done_rise) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else if (timeout_hit) begin
                        busy        <= 1'b0;
                        timeout_err <= 1'b1;
                        state       <= ST_IDLE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_sample_buffer.sv
// Bench for adc_sample_buffer: directed scenarios plus randomized traffic against a queue-based model.
// Latency: n/a.
// Backpressure: n/a.
module tb_adc_sample_buffer;
    import adc_sample_buffer_pkg::*;

    localparam int W       = K;
    localparam int DEPTH   = 8;
    localparam int AW      = 3;
    localparam int TIMEOUT = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          ready;
    logic [23:0]   l_in;
    logic [23:0]   r_in;
    logic          filter_done;
    logic [W-1:0]  data_out;
    logic          sample;
    logic          busy;
    logic [AW:0]   count;
    logic          overflow;
    logic          timeout_err;

    adc_sample_buffer #(
        .k       (W),
        .DEPTH   (DEPTH),
        .AW      (AW),
        .MIX     (MIX_AVG),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ready       (ready),
        .L_bus_out   (l_in),
        .R_bus_out   (r_in),
        .filter_done (filter_done),
        .data_out    (data_out),
        .sample      (sample),
        .busy        (busy),
        .count       (count),
        .overflow    (overflow),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: a queue of mono samples plus the sample currently handed to notch_top.
    logic [W-1:0] m_q[$];
    logic [W-1:0] m_data;
    bit           m_wait, m_sample, m_busy, m_ovf, m_terr;
    bit           m_ready_prev, m_done_prev;
    int           m_since;

    // Mono average rounded toward minus infinity, computed on plain integers.
    function automatic logic [W-1:0] mix_avg(input logic [23:0] l, input logic [23:0] r);
        int s;
        s = int'($signed(l)) + int'($signed(r));
        if (s >= 0) return W'(s / 2);
        return W'(-((1 - s) / 2));
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_data = '0;
        m_wait = 0; m_sample = 0; m_busy = 0; m_ovf = 0; m_terr = 0;
        m_ready_prev = 0; m_done_prev = 0;
        m_since = 0;
    endtask

    task automatic model_step();
        bit rise, done_edge;
        rise      = ready && !m_ready_prev;
        done_edge = filter_done && !m_done_prev;
        m_sample  = 0;
        if (!m_wait) begin
            if (m_q.size() != 0) begin
                m_data   = m_q.pop_front();
                m_sample = 1;
                m_busy   = 1;
                m_wait   = 1;
                m_since  = 0;
            end
        end else begin
            m_since++;
            if (done_edge) begin
                m_wait = 0;
                m_busy = 0;
            end else if (TIMEOUT != 0 && m_since == TIMEOUT) begin
                m_wait = 0;
                m_busy = 0;
                m_terr = 1;
            end
        end
        if (rise) begin
            if (m_q.size() < DEPTH) m_q.push_back(mix_avg(l_in, r_in));
            else                    m_ovf = 1;
        end
        m_ready_prev = ready;
        m_done_prev  = filter_done;
    endtask

    task automatic compare_all();
        check_eq("data_out",    32'(data_out),    32'(m_data));
        check_eq("sample",      32'(sample),      32'(m_sample));
        check_eq("busy",        32'(busy),        32'(m_busy));
        check_eq("count",       32'(count),       32'(m_q.size()));
        check_eq("overflow",    32'(overflow),    32'(m_ovf));
        check_eq("timeout_err", 32'(timeout_err), 32'(m_terr));
    endtask

    // One clock: model advances on the edge, DUT compared on the falling edge.
    task automatic tick();
        @(posedge clk);
        if (reset) model_reset();
        else       model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        ready       = 1'b0;
        filter_done = 1'b0;
        reset       = 1'b1;
        #1;
        model_reset();
        compare_all();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic frame_ack(input string tag, input logic [23:0] l, input logic [23:0] r,
                             input logic [23:0] exp);
        l_in = l; r_in = r; ready = 1'b1;
        tick();
        ready = 1'b0;
        tick();
        check_eq({tag, "_strobe"}, 32'(sample), 32'd1);
        check_eq({tag, "_data"}, 32'(data_out), 32'(exp));
        filter_done = 1'b1;
        tick();
        filter_done = 1'b0;
        tick();
        check_eq({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    function automatic logic [23:0] pick_sample();
        case ($urandom_range(0, 5))
            0:       return 24'h7FFFFF;
            1:       return 24'h800000;
            2:       return 24'hFFFFFF;
            3:       return 24'h000000;
            default: return 24'($urandom);
        endcase
    endfunction

    initial begin
        int n;
        int strobes;
        int max_cnt;
        int ph;
        reset = 1'b1; ready = 1'b0; filter_done = 1'b0; l_in = '0; r_in = '0;
        do_reset();
        check_eq("rst_sample",   32'(sample),      32'd0);
        check_eq("rst_busy",     32'(busy),        32'd0);
        check_eq("rst_count",    32'(count),       32'd0);
        check_eq("rst_data",     32'(data_out),    32'd0);
        check_eq("rst_overflow", 32'(overflow),    32'd0);
        check_eq("rst_timeout",  32'(timeout_err), 32'd0);

        // Single frame: capture, strobe two edges later, busy until done rises.
        l_in = 24'h000100; r_in = 24'h000300; ready = 1'b1;
        tick();
        check_eq("t1_count_after_capture", 32'(count), 32'd1);
        check_eq("t1_no_strobe_yet", 32'(sample), 32'd0);
        ready = 1'b0;
        tick();
        check_eq("t1_strobe", 32'(sample), 32'd1);
        check_eq("t1_data", 32'(data_out), 32'h000200);
        tick();
        check_eq("t1_strobe_one_cycle", 32'(sample), 32'd0);
        check_eq("t1_busy_held", 32'(busy), 32'd1);
        filter_done = 1'b1;
        tick();
        filter_done = 1'b0;
        check_eq("t1_busy_cleared", 32'(busy), 32'd0);
        tick();

        // Sign handling and no wrap on the average.
        frame_ack("t2_neg", 24'hFFFFFF, 24'h000000, 24'hFFFFFF);
        frame_ack("t2_pos_max", 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF);
        frame_ack("t2_neg_max", 24'h800000, 24'h800000, 24'h800000);
        frame_ack("t2_mixed", 24'h000005, 24'hFFFFF8, 24'hFFFFFE);

        // Done edge on the same cycle the timeout would fire: done wins.
        l_in = 24'h000010; r_in = 24'h000020; ready = 1'b1;
        tick();
        ready = 1'b0;
        tick();
        repeat (TIMEOUT - 1) tick();
        check_eq("t5b_busy_before", 32'(busy), 32'd1);
        filter_done = 1'b1;
        tick();
        filter_done = 1'b0;
        check_eq("t5b_busy_dropped", 32'(busy), 32'd0);
        check_eq("t5b_no_timeout_err", 32'(timeout_err), 32'd0);
        tick();

        // Timeout with a second frame queued behind the stalled one.
        l_in = 24'h000111; r_in = 24'h000111; ready = 1'b1;
        tick();
        ready = 1'b0;
        tick();
        l_in = 24'h000222; r_in = 24'h000222; ready = 1'b1;
        tick();
        ready = 1'b0;
        n = 1;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        check_eq("t5_timeout_cycles", 32'(n), TIMEOUT);
        check_eq("t5_timeout_err", 32'(timeout_err), 32'd1);
        tick();
        check_eq("t5_next_strobe", 32'(sample), 32'd1);
        check_eq("t5_next_data", 32'(data_out), 32'h000222);
        repeat (TIMEOUT + 4) tick();

        // Ready held high: exactly one push.
        strobes = 0;
        l_in = 24'h000042; r_in = 24'h000042; ready = 1'b1;
        repeat (100) begin
            tick();
            if (sample) strobes++;
        end
        ready = 1'b0;
        check_eq("t4_one_strobe", 32'(strobes), 32'd1);
        check_eq("t4_count_empty", 32'(count), 32'd0);

        // Fill past capacity while notch_top never answers.
        do_reset();
        check_eq("t3_overflow_clear", 32'(overflow), 32'd0);
        max_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            l_in = 24'(i * 16); r_in = 24'(i * 16 + 2); ready = 1'b1;
            tick();
            if (int'(count) > max_cnt) max_cnt = int'(count);
            ready = 1'b0;
            tick();
            if (int'(count) > max_cnt) max_cnt = int'(count);
        end
        check_eq("t3_overflow_set", 32'(overflow), 32'd1);
        check_eq("t3_max_count", 32'(max_cnt), DEPTH);
        n = 0;
        while ((count != 0 || busy) && n < 400) begin
            filter_done = ~filter_done;
            tick();
            n++;
        end
        filter_done = 1'b0;
        tick();
        check_eq("t3_drained", 32'(count), 32'd0);

        // Reset while waiting with three frames queued.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            l_in = 24'(i + 1); r_in = 24'(i + 1); ready = 1'b1;
            tick();
            ready = 1'b0;
            if (i < 3) tick();
        end
        check_eq("t6_count_before", 32'(count), 32'd3);
        check_eq("t6_busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        model_reset();
        check_eq("t6_sample_async", 32'(sample), 32'd0);
        check_eq("t6_busy_async", 32'(busy), 32'd0);
        check_eq("t6_count_async", 32'(count), 32'd0);
        check_eq("t6_overflow_async", 32'(overflow), 32'd0);
        tick();
        reset = 1'b0;
        strobes = 0;
        repeat (10) begin
            tick();
            if (sample) strobes++;
        end
        check_eq("t6_no_strobe_after_reset", 32'(strobes), 32'd0);

        // Randomized traffic in three done-rate regimes, with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            ph = i / 1000;
            if ($urandom_range(0, 1) == 1) ready = ~ready;
            if ($urandom_range(0, 2) == 0) l_in = pick_sample();
            if ($urandom_range(0, 2) == 0) r_in = pick_sample();
            case (ph)
                0:       filter_done = ($urandom_range(0, 3) == 0);
                1:       filter_done = ($urandom_range(0, 40) == 0);
                default: filter_done = ($urandom_range(0, 1) == 0);
            endcase
            if ($urandom_range(0, 599) == 0) do_reset();
            else                             tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
